seg_disp_arbiter: RTL and testbench
===================================

// Module: seg_disp_arbiter
// PURPOSE
//  Shares the 4-digit 7-segment display between N_REQ pattern clients, e.g. the
//  rotating-segment animation and a hex/message source.
//  - Grants the display to one client at a time (round-robin, req/gnt handshake).
//  - Time-multiplexes the owner's four digit patterns onto seg/an.
//  - Inserts a blanking gap on every ownership change.
//  Sits between the pattern generators and the board pins.
// PARAMETERS
//  N_REQ        2      number of requesting clients (>=2)
//  REFRESH_DIV  50000  clk cycles per digit slot
//  MIN_FRAMES   4      full scans an owner keeps gnt before it can be preempted
//  BLANK_CYC    16     clk cycles of blank display between owners (>=1)
// PORTS
//  clk    in   1         system clock, all logic on posedge
//  reset  in   1         synchronous, active-high
//  req    in   N_REQ     req[i]=1: client i wants the display; held until done
//  pat    in   N_REQ*28  client i digit d pattern = pat[28*i+7*d +: 7], abcdefg, 1=lit
//  gnt    out  N_REQ     one-hot/zero grant, registered
//  seg    out  7         segment drive, abcdefg, 1=lit, registered
//  an     out  4         digit enable, active-low, an[d] for digit d, registered
//  frame  out  1         1-cycle pulse when digit 3 slot ends (scan wrap)
// BEHAVIOUR
//  Reset (sync): gnt=0, seg=7'h00, an=4'hF, frame=0, state=IDLE, rr_ptr=0,
//    digit=0, scan_cnt=0, frame_cnt=0, blank_cnt=0.
//  Scan timer (free-running, independent of arbitration):
//  - scan_cnt counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps and digit
//    advances 0->1->2->3->0.
//  - frame=1 on the cycle digit wraps 3->0.
//  - scan_cnt width = $clog2(REFRESH_DIV).
//  States:
//  - IDLE: seg=0, an=F. If |req, pick the first set bit at or after rr_ptr (cyclic).
//    Next cycle: gnt=onehot(winner), owner=winner, frame_cnt=0, ->GRANT.
//    Arbitration latency is 1 cycle.
//  - GRANT: each cycle, an <= ~(4'b1<<digit), seg <= pat[owner][digit]. Data shows
//    1 cycle after pat/digit change. frame_cnt increments on frame and saturates
//    at MIN_FRAMES.
//  - GRANT, release: req[owner]=0 -> next cycle gnt=0, rr_ptr=owner+1 mod N_REQ,
//    blank_cnt=0, ->BLANK. Any cycle, no frame wait.
//  - GRANT, preempt: other req set, frame=1, frame_cnt>=MIN_FRAMES-1 (i.e. the
//    MIN_FRAMES-th frame is ending) -> same actions as release.
//  - BLANK: seg=0, an=F, gnt=0 for BLANK_CYC cycles, then ->IDLE. A req that
//    arrives during BLANK is arbitrated in IDLE.
//  Boundary rules:
//  - Release and preempt in the same cycle: treat as release (identical next state).
//  - A non-owner dropping req has no effect. A sole owner is never preempted.
//  - gnt changes only on state transitions. At most one gnt bit is set; none in
//    IDLE/BLANK.
//  - pat is sampled live while granted, so a client can animate under its grant.
//  - Reset mid-GRANT/BLANK: all outputs take reset values on that edge. No partial
//    frame survives.
// STRUCTURE
//  seg_pkg:
//  - typedef enum logic [1:0] {IDLE, GRANT, BLANK} arb_state_t;
//  - localparams SEG_OFF=7'h00, AN_OFF=4'hF, NUM_DIGITS=4, DIGIT_W=7.
//  Sub-module seg_scan_timer #(REFRESH_DIV):
//  - ports: clk, reset -> digit[1:0], frame.
//  - instanced once.
//  The arbiter FSM, rr pick and output registers live in the top module.
// TESTING  (bench params REFRESH_DIV=4, MIN_FRAMES=2, BLANK_CYC=3, N_REQ=2)
//  1 Reset held 2 cycles, req=2'b11 -> gnt=00, seg=00, an=F throughout. After
//    release, first frame pulse is 16 cycles later.
//  2 req=01, pat[0] digits = 3F,06,5B,4F -> gnt=01 1 cycle later. an cycles
//    E,D,B,7, 4 cycles each; seg=3F,06,5B,4F in the matching slots.
//  3 From IDLE req=11, rr_ptr=0 -> gnt=01. At the end of the 2nd frame (32 cycles):
//    gnt=00, an=F for 3 cycles, then gnt=10.
//  4 Owner 0 drops req mid-digit-1 with req[1]=0 -> gnt=00 next cycle, 3 blank
//    cycles, then IDLE. Re-raise req=01 -> gnt=01 (rr_ptr=1 is skipped, no req1).
//  5 Owner drops req on the same cycle a preempt would fire -> single release
//    path, BLANK exactly 3 cycles, gnt never shows two bits.
//  6 reset pulse while gnt=10 mid-frame -> next edge gnt=00, an=F, seg=00, state
//    IDLE, rr_ptr=0.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the 7-segment display arbiter
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BLANK = 2'd2
    } arb_state_t;

    localparam logic [6:0] SEG_OFF    = 7'h00;
    localparam logic [3:0] AN_OFF     = 4'hF;
    localparam int         NUM_DIGITS = 4;
    localparam int         DIGIT_W    = 7;

endpackage

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - free-running digit slot timer with registered frame pulse
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] digit,
    output logic       frame
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [1:0]       DIGIT_LAST = 2'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic             frame_q, frame_d;

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        digit_d    = digit_q;
        if (scan_cnt_q == CNT_LAST) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end
        // Pulse is visible in the first cycle after the digit 3 -> 0 wrap
        frame_d = (scan_cnt_q == CNT_LAST) && (digit_q == DIGIT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q <= '0;
            digit_q    <= 2'd0;
            frame_q    <= 1'b0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            frame_q    <= frame_d;
        end
    end

    assign digit = digit_q;
    assign frame = frame_q;

endmodule

// File: rtl/seg_disp_arbiter.sv
// rtl/seg_disp_arbiter.sv - round-robin owner of the 4-digit display with
// minimum-hold preemption and a blanking gap between owners
module seg_disp_arbiter
    import seg_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int REFRESH_DIV = 50000,
    parameter int MIN_FRAMES  = 4,
    parameter int BLANK_CYC   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*28-1:0]   pat,
    output logic [N_REQ-1:0]      gnt,
    output logic [6:0]            seg,
    output logic [3:0]            an,
    output logic                  frame
);

    localparam int RR_W = $clog2(N_REQ);
    localparam int FC_W = $clog2(MIN_FRAMES + 1);
    localparam int BC_W = $clog2(BLANK_CYC + 1);
    localparam logic [FC_W-1:0] FC_MAX     = FC_W'(MIN_FRAMES);
    localparam logic [FC_W-1:0] FC_PREEMPT = FC_W'(MIN_FRAMES - 1);
    localparam logic [BC_W-1:0] BC_LAST    = BC_W'(BLANK_CYC - 1);
    localparam logic [RR_W-1:0] RR_LAST    = RR_W'(N_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [RR_W-1:0]  owner_q, owner_d;
    logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [BC_W-1:0]  blank_cnt_q, blank_cnt_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic [1:0]       digit;
    logic             scan_frame;
    logic             pick_found;
    logic [RR_W-1:0]  pick_idx;
    logic             release_c;
    logic             preempt_c;
    logic [6:0]       owner_pat;
    int               pick_j;

    seg_scan_timer #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .digit (digit),
        .frame (scan_frame)
    );

    // First requester at or after rr_ptr, searching cyclically
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            pick_j = (int'(rr_ptr_q) + i) % N_REQ;
            if (!pick_found && req[pick_j]) begin
                pick_found = 1'b1;
                pick_idx   = RR_W'(pick_j);
            end
        end
    end

    always_comb begin
        owner_pat = pat[DIGIT_W * (NUM_DIGITS * int'(owner_q) + int'(digit)) +: DIGIT_W];
        release_c = !req[owner_q];
        preempt_c = scan_frame && (frame_cnt_q >= FC_PREEMPT) && |(req & ~gnt_q);
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        frame_cnt_d = frame_cnt_q;
        blank_cnt_d = blank_cnt_q;
        seg_d       = SEG_OFF;
        an_d        = AN_OFF;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    gnt_d       = N_REQ'(1) << pick_idx;
                    owner_d     = pick_idx;
                    frame_cnt_d = '0;
                end
            end
            GRANT: begin
                seg_d = owner_pat;
                an_d  = ~(4'b0001 << digit);
                if (scan_frame && (frame_cnt_q < FC_MAX)) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
                // Release and preempt share one exit path into the blanking gap
                if (release_c || preempt_c) begin
                    state_d     = BLANK;
                    gnt_d       = '0;
                    rr_ptr_d    = (owner_q == RR_LAST) ? '0 : owner_q + 1'b1;
                    blank_cnt_d = '0;
                    seg_d       = SEG_OFF;
                    an_d        = AN_OFF;
                end
            end
            BLANK: begin
                if (blank_cnt_q == BC_LAST) begin
                    state_d = IDLE;
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            frame_cnt_q <= '0;
            blank_cnt_q <= '0;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign gnt   = gnt_q;
    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = scan_frame;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb/tb_seg_disp_arbiter.sv - directed self-checking bench for seg_disp_arbiter
module tb_seg_disp_arbiter;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req   = 2'b00;
    logic [55:0] pat;
    logic [1:0]  gnt;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int total = 0;
    int bad   = 0;

    localparam logic [27:0] PAT0 = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    localparam logic [27:0] PAT1 = {7'h5E, 7'h39, 7'h7C, 7'h77};

    logic [6:0] exp_seg [4] = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
    logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    seg_disp_arbiter #(
        .N_REQ       (2),
        .REFRESH_DIV (4),
        .MIN_FRAMES  (2),
        .BLANK_CYC   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .pat   (pat),
        .gnt   (gnt),
        .seg   (seg),
        .an    (an),
        .frame (frame)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (frame === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        req   = 2'b11;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b want=00", gnt); end
            total++; if (seg !== 7'h00) begin bad++; $display("FAIL rst_seg got=%h want=00", seg); end
            total++; if (an !== 4'hF)   begin bad++; $display("FAIL rst_an got=%h want=f", an); end
            total++; if (frame !== 1'b0) begin bad++; $display("FAIL rst_frame got=%b want=0", frame); end
        end
        reset = 1'b0;
        req   = 2'b00;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if (frame === 1'b1) break;
        end
        total++; if (n != 16) begin bad++; $display("FAIL rst_first_frame got=%0d want=16", n); end
    endtask

    task automatic test_scan_display();
        bit ok;
        wait_frame(ok);
        total++; if (!ok) begin bad++; $display("FAIL scan_align got=timeout want=frame"); end
        for (int i = 0; i < 12; i++) step();
        req = 2'b01;
        step();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL scan_gnt got=%b want=01", gnt); end
        for (int i = 0; i < 3; i++) step();
        for (int k = 0; k < 16; k++) begin
            step();
            total++; if (an !== exp_an[k/4]) begin bad++; $display("FAIL scan_an k=%0d got=%h want=%h", k, an, exp_an[k/4]); end
            total++; if (seg !== exp_seg[k/4]) begin bad++; $display("FAIL scan_seg k=%0d got=%h want=%h", k, seg, exp_seg[k/4]); end
        end
    endtask

    task automatic test_preempt();
        bit ok;
        int n;
        do_reset();
        wait_frame(ok);
        total++; if (!ok) begin bad++; $display("FAIL pre_align got=timeout want=frame"); end
        req = 2'b11;
        step();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL pre_first_gnt got=%b want=01", gnt); end
        n = 0;
        while (gnt === 2'b01 && n < 40) begin
            n++;
            step();
        end
        total++; if (n != 32) begin bad++; $display("FAIL pre_hold_cycles got=%0d want=32", n); end
        for (int i = 0; i < 3; i++) begin
            total++; if (gnt !== 2'b00) begin bad++; $display("FAIL pre_blank_gnt i=%0d got=%b want=00", i, gnt); end
            total++; if (an !== 4'hF)   begin bad++; $display("FAIL pre_blank_an i=%0d got=%h want=f", i, an); end
            step();
        end
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL pre_idle_gnt got=%b want=00", gnt); end
        step();
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL pre_next_gnt got=%b want=10", gnt); end
    endtask

    task automatic test_release();
        bit ok;
        do_reset();
        wait_frame(ok);
        total++; if (!ok) begin bad++; $display("FAIL rel_align got=timeout want=frame"); end
        req = 2'b11;
        step();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rel_gnt got=%b want=01", gnt); end
        req = 2'b01;
        step();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rel_nonowner_drop got=%b want=01", gnt); end
        for (int i = 0; i < 3; i++) step();
        total++; if (an !== 4'hD)   begin bad++; $display("FAIL rel_mid_an got=%h want=d", an); end
        total++; if (seg !== 7'h06) begin bad++; $display("FAIL rel_mid_seg got=%h want=06", seg); end
        req = 2'b00;
        step();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rel_drop_gnt got=%b want=00", gnt); end
        total++; if (seg !== 7'h00) begin bad++; $display("FAIL rel_drop_seg got=%h want=00", seg); end
        total++; if (an !== 4'hF)   begin bad++; $display("FAIL rel_drop_an got=%h want=f", an); end
        step();
        step();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rel_blank_gnt got=%b want=00", gnt); end
        req = 2'b01;
        step();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rel_idle_gnt got=%b want=00", gnt); end
        step();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rel_regrant got=%b want=01", gnt); end
    endtask

    task automatic test_release_and_preempt();
        bit ok;
        do_reset();
        wait_frame(ok);
        total++; if (!ok) begin bad++; $display("FAIL both_align got=timeout want=frame"); end
        req = 2'b11;
        step();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL both_first_gnt got=%b want=01", gnt); end
        for (int i = 1; i < 32; i++) begin
            step();
            total++; if (gnt !== 2'b01) begin bad++; $display("FAIL both_hold i=%0d got=%b want=01", i, gnt); end
        end
        total++; if (frame !== 1'b1) begin bad++; $display("FAIL both_frame got=%b want=1", frame); end
        req = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (gnt !== 2'b00) begin bad++; $display("FAIL both_gap_gnt i=%0d got=%b want=00", i, gnt); end
            if (i < 3) begin
                total++; if (an !== 4'hF) begin bad++; $display("FAIL both_gap_an i=%0d got=%h want=f", i, an); end
            end
        end
        step();
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL both_next_gnt got=%b want=10", gnt); end
    endtask

    task automatic test_reset_mid_grant();
        for (int i = 0; i < 5; i++) step();
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL midrst_pre_gnt got=%b want=10", gnt); end
        total++; if (an === 4'hF)   begin bad++; $display("FAIL midrst_pre_an got=%h want=not f", an); end
        reset = 1'b1;
        step();
        total++; if (gnt !== 2'b00)  begin bad++; $display("FAIL midrst_gnt got=%b want=00", gnt); end
        total++; if (an !== 4'hF)    begin bad++; $display("FAIL midrst_an got=%h want=f", an); end
        total++; if (seg !== 7'h00)  begin bad++; $display("FAIL midrst_seg got=%h want=00", seg); end
        total++; if (frame !== 1'b0) begin bad++; $display("FAIL midrst_frame got=%b want=0", frame); end
        reset = 1'b0;
        req   = 2'b11;
        step();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL midrst_rrptr got=%b want=01", gnt); end
    endtask

    initial begin
        pat = {PAT1, PAT0};
        test_reset();
        test_scan_display();
        test_preempt();
        test_release();
        test_release_and_preempt();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
